multicycle_control: RTL

Multicycle sequencer for the RV64 load/store/branch datapath. It replaces single-cycle decode with a registered state machine (FETCH → DECODE → EXEC → MEM → WB) that drives:
- the PC, instruction-register and register-file write enables;
- the data-memory strobes and the ALU-source/ALU-op selects.

It handshakes with instruction and data memories that may insert wait states, traps on unsupported opcodes, and keeps cycle and retired-instruction counters.

---
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the RV64 load/store/branch datapath.
// A registered FETCH/DECODE/EXEC/MEM/WB state machine drives PC, IR and
// register-file enables, data-memory strobes and ALU selects; it waits on
// instruction/data memory ready, traps on unsupported opcodes and keeps
// active-cycle and retired-instruction counters.
module multicycle_control #(
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,        // asynchronous, active-low
  input  logic             i_run,
  input  logic [6:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  output logic             o_imem_req,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_pc_src,
  output logic             o_reg_write,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_mem_to_reg,
  output logic             o_alu_src,
  output logic [1:0]       o_alu_op,
  output logic             o_illegal,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_instret_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6,
    ST_UNUSED = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [6:0]       r_opcode;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_instret_count;
  logic             w_supported;
  logic             w_retire;
  logic             w_count_cycle;

  // Opcode classification used only while the IR is being decoded.
  always_comb begin
    w_supported = 1'b0;
    case (i_opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: w_supported = 1'b1;
      default:                                  w_supported = 1'b0;
    endcase
  end

  // Next-state and combinational strobes; everything defaults to 0 / hold.
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    o_imem_req   = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_src    = 1'b0;
    o_alu_op     = ALU_ADD;
    case (r_state)
      ST_IDLE: begin
        if (i_run) w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          o_ir_write   = 1'b1;
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_next_state = w_supported ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        case (r_opcode)
          OP_R: begin
            o_alu_op     = ALU_FUNCT;
            w_next_state = ST_WB;
          end
          OP_I: begin
            o_alu_src    = 1'b1;
            o_alu_op     = ALU_FUNCT;
            w_next_state = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            o_alu_src    = 1'b1;
            w_next_state = ST_MEM;
          end
          OP_BRANCH: begin
            o_alu_op   = ALU_BRANCH;
            o_pc_write = 1'b1;
            o_pc_src   = i_zero;
            w_retire   = 1'b1;
          end
          default: w_next_state = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        // Address computation stays selected while the access is pending.
        o_alu_src = 1'b1;
        if (r_opcode == OP_LOAD) begin
          o_mem_read = 1'b1;
          if (i_dmem_ready) w_next_state = ST_WB;
        end else begin
          o_mem_write = 1'b1;
          if (i_dmem_ready) begin
            o_pc_write = 1'b1;
            w_retire   = 1'b1;
          end
        end
      end
      ST_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = (r_opcode == OP_LOAD);
        o_pc_write   = 1'b1;
        w_retire     = 1'b1;
      end
      ST_TRAP: begin
        w_next_state = ST_TRAP;
      end
      default: w_next_state = ST_IDLE;
    endcase
    // run is only looked at on an instruction boundary.
    if (w_retire) w_next_state = i_run ? ST_FETCH : ST_IDLE;
  end

  assign w_count_cycle = (r_state != ST_IDLE) && (r_state != ST_TRAP);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Capture the opcode in DECODE so later states ignore IR changes.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                 r_opcode <= 7'd0;
    else if (r_state == ST_DECODE) r_opcode <= i_opcode;
  end

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                                   r_illegal <= 1'b0;
    else if ((r_state == ST_DECODE) && !w_supported) r_illegal <= 1'b1;
  end

  // Free-wrapping active-cycle and retired-instruction counters.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cycle_count   <= '0;
      r_instret_count <= '0;
    end else begin
      if (w_count_cycle) r_cycle_count   <= r_cycle_count + CNT_ONE;
      if (w_retire)      r_instret_count <= r_instret_count + CNT_ONE;
    end
  end

  assign o_illegal       = r_illegal;
  assign o_state         = r_state;
  assign o_cycle_count   = r_cycle_count;
  assign o_instret_count = r_instret_count;

endmodule
